rev_univ_shift_reg: RTL

Parametrised universal shift register whose per-bit next-state select is built from reversible Fredkin-based 4:1 multiplexer cells (three `mux2` cells per bit, garbage lines left internal). It supports hold, shift right, shift left and parallel load at any `WIDTH`. A burst sequencer performs N back-to-back shifts from a single `start` pulse. It is the storage/shift stage of the reversible shift-register datapath.

---
 rtl/rev_univ_shift_reg.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rev_univ_shift_reg.sv
// Universal shift register (hold/shr/shl/load) with per-bit Fredkin mux4 select and a burst sequencer.
// Latency: 1 cycle per manual op; a burst of N shifts occupies N+1 cycles after start, then one DONE cycle.
// Backpressure: none; start/en are sampled only in IDLE and ignored while busy or done. Option: REVSR_ROTATE_EN.

// Controlled-swap (Fredkin) gate used as a 2:1 mux. Only the data line that
// carries the selected input leaves the cell; the swapped line and the control
// copy stay inside as garbage.
module rev_mux2 (
    input  logic c,
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = (~c & a) | (c & b);
endmodule

module rev_univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             sir,
    input  logic             sil,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       lmode;
    logic [LEN_W-1:0] cnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] q_nxt;
    logic             sr_in;
    logic             sl_in;
    logic             burst_req;

    // Only the two shift modes start a burst; hold/load requests fall through to a manual cycle.
    assign burst_req = start && (mode[0] ^ mode[1]);

`ifdef REVSR_ROTATE_EN
    assign sr_in = q[0];
    assign sl_in = q[WIDTH-1];
`else
    assign sr_in = sir;
    assign sl_in = sil;
`endif

    always_comb begin
        sel = 2'b00;
        case (state)
            IDLE: begin
                if (burst_req)
                    sel = 2'b00;
                else if (en)
                    sel = mode;
            end
            SHIFT:   sel = lmode;
            default: sel = 2'b00;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic right_src;
        logic left_src;
        logic m_lo;
        logic m_hi;

        if (i == WIDTH - 1) begin : g_msb
            assign right_src = sr_in;
        end else begin : g_mid_r
            assign right_src = q[i+1];
        end

        if (i == 0) begin : g_lsb
            assign left_src = sl_in;
        end else begin : g_mid_l
            assign left_src = q[i-1];
        end

        rev_mux2 u_lo  (.c(sel[0]), .a(q[i]),     .b(right_src), .y(m_lo));
        rev_mux2 u_hi  (.c(sel[0]), .a(left_src), .b(d[i]),      .y(m_hi));
        rev_mux2 u_out (.c(sel[1]), .a(m_lo),     .b(m_hi),      .y(q_nxt[i]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            cnt   <= '0;
            lmode <= 2'b00;
            state <= IDLE;
        end else begin
            q <= q_nxt;
            case (state)
                IDLE: begin
                    if (burst_req) begin
                        lmode <= mode;
                        cnt   <= len;
                        state <= (len != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - {{(LEN_W-1){1'b0}}, 1'b1};
                    if (cnt == {{(LEN_W-1){1'b0}}, 1'b1})
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign so_r = q[0];
    assign so_l = q[WIDTH-1];
    assign busy = (state == SHIFT);
    assign done = (state == DONE);
endmodule
